seq_divider: RTL and testbench

- Iterative radix-2 divider that performs the inverse operation of the pipelined Booth multiplier.
- Accepts one dividend/divisor pair through a valid/ready handshake and produces quotient and remainder after a fixed latency.
- Signed or unsigned operation is selected by parameter.
- Sits beside the multiplier in the arithmetic library and is verified by a sweep bench of the same style (counter-driven operands, golden check against the simulator's `/` and `%`).

---
 rtl/seq_divider.sv | 189 ++++++++++++++++++
 tb/tb_seq_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider with valid/ready operand and result handshakes.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module seq_divider #(
    parameter int N_W      = 16,
    parameter int D_W      = 8,
    parameter int UNSIGNED = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_by_zero
);

    localparam int CNT_W = $clog2(N_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_W - 1);
    localparam bit SIGNED_OPS = (UNSIGNED == 32'sd0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    // dvd_q shifts dividend bits out of the MSB while quotient bits enter at the LSB.
    logic [N_W-1:0] dvd_q, dvd_d;
    logic [D_W-1:0] dvs_q, dvs_d;
    logic [D_W:0]   prem_q, prem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           q_neg_q, q_neg_d;
    logic           r_neg_q, r_neg_d;
    logic           dz_q, dz_d;
    logic [D_W-1:0] dz_rem_q, dz_rem_d;
    logic [N_W-1:0] quotient_q, quotient_d;
    logic [D_W-1:0] remainder_q, remainder_d;
    logic           out_valid_q, out_valid_d;
    logic           div_by_zero_q, div_by_zero_d;

    logic           in_ready_s;
    logic           dvd_neg_s, dvs_neg_s;
    logic [N_W-1:0] dvd_mag_s;
    logic [D_W-1:0] dvs_mag_s;
    logic [D_W:0]   shifted_s;
    logic [D_W+1:0] diff_s;
    logic           step_ok_s;
    logic [N_W-1:0] q_fix_s;
    logic [D_W-1:0] r_fix_s;

    assign in_ready_s = (state_q == IDLE) && !rst;

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign dvd_neg_s = SIGNED_OPS && dividend[N_W-1];
    assign dvs_neg_s = SIGNED_OPS && divisor[D_W-1];
    assign dvd_mag_s = dvd_neg_s ? (-dividend) : dividend;
    assign dvs_mag_s = dvs_neg_s ? (-divisor) : divisor;

    assign shifted_s = {prem_q[D_W-1:0], dvd_q[N_W-1]};
    assign diff_s    = {1'b0, shifted_s} - {2'b00, dvs_q};
    assign step_ok_s = ~diff_s[D_W+1];

    assign q_fix_s = q_neg_q ? (-dvd_q) : dvd_q;
    assign r_fix_s = r_neg_q ? (-prem_q[D_W-1:0]) : prem_q[D_W-1:0];

    // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
    always_comb begin
        state_d       = state_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        prem_d        = prem_q;
        cnt_d         = cnt_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        dz_d          = dz_q;
        dz_rem_d      = dz_rem_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        out_valid_d   = out_valid_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_s) begin
                    dvd_d    = dvd_mag_s;
                    dvs_d    = dvs_mag_s;
                    q_neg_d  = dvd_neg_s ^ dvs_neg_s;
                    r_neg_d  = dvd_neg_s;
                    dz_d     = (divisor == {D_W{1'b0}});
                    dz_rem_d = dividend[D_W-1:0];
                    prem_d   = {(D_W+1){1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
`ifdef DIV_ZERO_FAST_EN
                    if (divisor == {D_W{1'b0}}) begin
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
`else
                    state_d  = CALC;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                prem_d = step_ok_s ? diff_s[D_W:0] : shifted_s;
                dvd_d  = {dvd_q[N_W-2:0], step_ok_s};
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                out_valid_d = 1'b1;
                state_d     = DONE;
                if (dz_q) begin
                    quotient_d    = {N_W{1'b1}};
                    remainder_d   = dz_rem_q;
                    div_by_zero_d = 1'b1;
                end else begin
                    quotient_d    = q_fix_s;
                    remainder_d   = r_fix_s;
                    div_by_zero_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            dvd_q         <= {N_W{1'b0}};
            dvs_q         <= {D_W{1'b0}};
            prem_q        <= {(D_W+1){1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dz_q          <= 1'b0;
            dz_rem_q      <= {D_W{1'b0}};
            quotient_q    <= {N_W{1'b0}};
            remainder_q   <= {D_W{1'b0}};
            out_valid_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dvd_q         <= dvd_d;
            dvs_q         <= dvs_d;
            prem_q        <= prem_d;
            cnt_q         <= cnt_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            dz_q          <= dz_d;
            dz_rem_q      <= dz_rem_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            out_valid_q   <= out_valid_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed checks on 16/8-bit signed and unsigned dividers plus an exhaustive 8/4-bit sweep.
module tb_seq_divider;

`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 17;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    // 16-bit pair: signed and unsigned instances share all inputs.
    logic        in16_valid = 1'b0;
    logic        out16_ready = 1'b1;
    logic [15:0] dvd16 = 16'h0000;
    logic [7:0]  dvs16 = 8'h00;
    logic        rdy16s, rdy16u, ov16s, ov16u, dz16s, dz16u;
    logic [15:0] q16s, q16u;
    logic [7:0]  r16s, r16u;

    // 8-bit pair for the exhaustive sweep.
    logic        in8_valid = 1'b0;
    logic        out8_ready = 1'b1;
    logic [7:0]  dvd8 = 8'h00;
    logic [3:0]  dvs8 = 4'h0;
    logic        rdy8s, rdy8u, ov8s, ov8u, dz8s, dz8u;
    logic [7:0]  q8s, q8u;
    logic [3:0]  r8s, r8u;

    always #5 clk = ~clk;

    seq_divider #(.N_W(16), .D_W(8), .UNSIGNED(0)) dut16s (
        .clk(clk), .rst(rst), .in_valid(in16_valid), .in_ready(rdy16s),
        .dividend(dvd16), .divisor(dvs16), .out_valid(ov16s), .out_ready(out16_ready),
        .quotient(q16s), .remainder(r16s), .div_by_zero(dz16s));

    seq_divider #(.N_W(16), .D_W(8), .UNSIGNED(1)) dut16u (
        .clk(clk), .rst(rst), .in_valid(in16_valid), .in_ready(rdy16u),
        .dividend(dvd16), .divisor(dvs16), .out_valid(ov16u), .out_ready(out16_ready),
        .quotient(q16u), .remainder(r16u), .div_by_zero(dz16u));

    seq_divider #(.N_W(8), .D_W(4), .UNSIGNED(0)) dut8s (
        .clk(clk), .rst(rst), .in_valid(in8_valid), .in_ready(rdy8s),
        .dividend(dvd8), .divisor(dvs8), .out_valid(ov8s), .out_ready(out8_ready),
        .quotient(q8s), .remainder(r8s), .div_by_zero(dz8s));

    seq_divider #(.N_W(8), .D_W(4), .UNSIGNED(1)) dut8u (
        .clk(clk), .rst(rst), .in_valid(in8_valid), .in_ready(rdy8u),
        .dividend(dvd8), .divisor(dvs8), .out_valid(ov8u), .out_ready(out8_ready),
        .quotient(q8u), .remainder(r8u), .div_by_zero(dz8u));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 16-bit operation; u selects which instance's result is checked.
    task automatic op16(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input bit u, input int hold, input int exp_lat,
                        input logic [15:0] eq, input logic [7:0] er, input logic ez);
        int lat;
        dvd16       = a;
        dvs16       = b;
        out16_ready = (hold == 0);
        in16_valid  = 1'b1;
        chk({tag, "_in_ready_idle"}, {31'd0, rdy16s}, 32'd1);
        @(posedge clk); #1;
        in16_valid = 1'b0;
        lat = 0;
        while (!(u ? ov16u : ov16s) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_quotient"}, {16'd0, (u ? q16u : q16s)}, {16'd0, eq});
        chk({tag, "_remainder"}, {24'd0, (u ? r16u : r16s)}, {24'd0, er});
        chk({tag, "_div_by_zero"}, {31'd0, (u ? dz16u : dz16s)}, {31'd0, ez});
        chk({tag, "_in_ready_busy"}, {31'd0, (u ? rdy16u : rdy16s)}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, {31'd0, (u ? ov16u : ov16s)}, 32'd1);
            chk({tag, "_hold_quotient"}, {16'd0, (u ? q16u : q16s)}, {16'd0, eq});
            chk({tag, "_hold_remainder"}, {24'd0, (u ? r16u : r16s)}, {24'd0, er});
            chk({tag, "_hold_in_ready"}, {31'd0, (u ? rdy16u : rdy16s)}, 32'd0);
        end
        out16_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_valid_cleared"}, {31'd0, (u ? ov16u : ov16s)}, 32'd0);
        chk({tag, "_in_ready_after"}, {31'd0, (u ? rdy16u : rdy16s)}, 32'd1);
    endtask

    initial begin
        int          lat;
        int          sa, sb, ua, ub, qi, ri;
        logic [7:0]  eqs, equ;
        logic [3:0]  ers, eru;
        logic        ezs, ezu;
        logic        seen;
        string       tg;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, ov16s}, 32'd0);
        chk("rst_quotient", {16'd0, q16s}, 32'd0);
        chk("rst_remainder", {24'd0, r16s}, 32'd0);
        chk("rst_div_by_zero", {31'd0, dz16s}, 32'd0);
        chk("rst_in_ready_low", {31'd0, rdy16s}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_after", {31'd0, rdy16s}, 32'd1);
        @(posedge clk); #1;

        // Directed 16-bit cases.
        op16("s_m100_div_7", 16'hFF9C, 8'h07, 1'b0, 0, 17, 16'hFFF2, 8'hFE, 1'b0);
        op16("s_overflow", 16'h8000, 8'hFF, 1'b0, 0, 17, 16'h8000, 8'h00, 1'b0);
        op16("u_65535_div_255", 16'hFFFF, 8'hFF, 1'b1, 0, 17, 16'h0101, 8'h00, 1'b0);
        op16("u_1000_div_3", 16'h03E8, 8'h03, 1'b1, 0, 17, 16'h014D, 8'h01, 1'b0);
        op16("s_div_zero", 16'h04D2, 8'h00, 1'b0, 0, DZ_LAT, 16'hFFFF, 8'hD2, 1'b1);
        op16("u_div_zero", 16'h04D2, 8'h00, 1'b1, 0, DZ_LAT, 16'hFFFF, 8'hD2, 1'b1);
        op16("s_backpressure", 16'h0032, 8'h05, 1'b0, 5, 17, 16'h000A, 8'h00, 1'b0);

        // Reset during the fourth CALC cycle aborts the operation.
        dvd16      = 16'h03E8;
        dvs16      = 8'h07;
        in16_valid = 1'b1;
        @(posedge clk); #1;
        in16_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_in_ready_in_rst", {31'd0, rdy16s}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_in_ready_after", {31'd0, rdy16s}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            seen = seen | ov16s | ov16u;
        end
        chk("abort_no_result", {31'd0, seen}, 32'd0);

        // Exhaustive 8/4-bit sweep on both signedness settings.
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 16; j++) begin
                dvd8 = i[7:0];
                dvs8 = j[3:0];
                sa = $signed(dvd8);
                sb = $signed(dvs8);
                ua = i;
                ub = j;
                if (sb == 0) begin
                    eqs = 8'hFF; ers = dvd8[3:0]; ezs = 1'b1;
                end else if (sa == -128 && sb == -1) begin
                    eqs = 8'h80; ers = 4'h0; ezs = 1'b0;
                end else begin
                    qi = sa / sb; ri = sa % sb;
                    eqs = qi[7:0]; ers = ri[3:0]; ezs = 1'b0;
                end
                if (ub == 0) begin
                    equ = 8'hFF; eru = dvd8[3:0]; ezu = 1'b1;
                end else begin
                    qi = ua / ub; ri = ua % ub;
                    equ = qi[7:0]; eru = ri[3:0]; ezu = 1'b0;
                end
                in8_valid = 1'b1;
                @(posedge clk); #1;
                in8_valid = 1'b0;
                lat = 0;
                while (!(ov8s && ov8u) && lat < 20) begin
                    @(posedge clk); #1;
                    lat++;
                end
                tg = $sformatf("sweep_a%0h_b%0h", dvd8, dvs8);
                chk({tg, "_done"}, {31'd0, (ov8s && ov8u)}, 32'd1);
                chk({tg, "_s_q"}, {24'd0, q8s}, {24'd0, eqs});
                chk({tg, "_s_r"}, {28'd0, r8s}, {28'd0, ers});
                chk({tg, "_s_dz"}, {31'd0, dz8s}, {31'd0, ezs});
                chk({tg, "_u_q"}, {24'd0, q8u}, {24'd0, equ});
                chk({tg, "_u_r"}, {28'd0, r8u}, {28'd0, eru});
                chk({tg, "_u_dz"}, {31'd0, dz8u}, {31'd0, ezu});
                @(posedge clk); #1;
            end
        end

        if (n_err == 0) begin
            $display("Testbench completed successfully!");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
